cntdiv_prog_n: RTL and testbench



---
 rtl/cntdiv_pkg.sv | 18 +
 rtl/cntdiv_ch.sv | 104 ++++++++++
 rtl/cntdiv_prog_n.sv | 40 ++++
 tb/tb_cntdiv_prog_n.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cntdiv_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
// Holds the output-mode encoding, the smallest legal divisor and the divisor
// clamp used when a new value is captured from the load bus.
package cntdiv_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } cntdiv_mode_e;

  localparam int unsigned MIN_DIV = 2;

  // Divisors of 0 or 1 cannot produce a defined period, so they become 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

endpackage

// File: rtl/cntdiv_ch.sv
// Single divider channel: counts 0..D-1 and emits tick/clkout, with divisor swaps only at period boundaries.
// Latency: outputs registered, 1 cycle from en/mode; div_load to div_ack is 1 cycle when disabled, else at the next wrap.
// Backpressure: none; free-running, every strobe is captured and the last load before the apply point wins.
// Ports: clk/rst (sync, active-high), en, mode (0 square, 1 pulse), div_in/div_load, div_ack, tick, clkout.
module cntdiv_ch
  import cntdiv_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int DEFAULT_DIV = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             tick,
  output logic             clkout
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(DEFAULT_DIV - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_q, tick_d;
  logic             clkout_q, clkout_d;
  logic             ack_q, ack_d;

  logic [WIDTH-1:0] load_val;
  logic             wrap;
  logic             apply;
  logic [WIDTH:0]   half;

  always_comb begin
    load_val = WIDTH'(clamp_div(32'(div_in)));
    wrap     = (cnt_q == (div_q - ONE));

    // A strobe on this very edge bypasses the pending register so a load
    // coinciding with the apply point lands immediately with a single ack.
    pend_d     = div_load ? load_val : pend_q;
    pend_vld_d = div_load | pend_vld_q;

    apply = pend_vld_d & (~en | wrap);
    div_d = apply ? pend_d : div_q;
    ack_d = apply;
    if (apply) begin
      pend_vld_d = 1'b0;
    end

    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    clkout_d = 1'b0;
    // ceil(D/2) from the divisor governing the next period.
    half     = ({1'b0, div_d} + ONE_X) >> 1;

    if (!en) begin
      // Primed at D-1 so the first enabled edge is a wrap.
      cnt_d = div_d - ONE;
    end else begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      if (cntdiv_mode_e'(mode) == MODE_PULSE) begin
        clkout_d = tick_d;
      end else begin
        clkout_d = ({1'b0, cnt_d} < half);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= RST_CNT;
      div_q      <= RST_DIV;
      pend_q     <= RST_DIV;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
      clkout_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      clkout_q   <= clkout_d;
      ack_q      <= ack_d;
    end
  end

  assign div_ack = ack_q;
  assign tick    = tick_q;
  assign clkout  = clkout_q;

endmodule

// File: rtl/cntdiv_prog_n.sv
// NCH independent programmable clock/tick dividers sharing only clk and rst.
// Latency: per channel, registered outputs; div_ack 1 cycle after load when disabled, else at the period end.
// Backpressure: none; loads are strobes, the last one before the apply point is taken.
// Ports: clk, rst (sync, active-high), en/mode/div_load/div_ack/tick/clkout [NCH], div_in [NCH*WIDTH].
module cntdiv_prog_n
  import cntdiv_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int WIDTH       = 24,
  parameter int DEFAULT_DIV = 100_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*WIDTH-1:0] div_in,
  input  logic [NCH-1:0]       div_load,
  output logic [NCH-1:0]       div_ack,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       clkout
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cntdiv_ch #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .mode    (mode[i]),
      .div_in  (div_in[i*WIDTH +: WIDTH]),
      .div_load(div_load[i]),
      .div_ack (div_ack[i]),
      .tick    (tick[i]),
      .clkout  (clkout[i])
    );
  end

endmodule

// File: tb/tb_cntdiv_prog_n.sv
module tb_cntdiv_prog_n;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int DD  = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en, mode, div_load, div_ack, tick, clkout;
  logic [NCH*W-1:0] div_in;

  cntdiv_prog_n #(.NCH(NCH), .WIDTH(W), .DEFAULT_DIV(DD)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .div_in(div_in),
    .div_load(div_load), .div_ack(div_ack), .tick(tick), .clkout(clkout)
  );

  always #5 clk = ~clk;

  // Reference model: position within the current period, active divisor,
  // pending divisor (-1 = none) and whether the channel has started a period.
  int m_d[NCH], m_pos[NCH], m_pend[NCH];
  bit m_run[NCH];
  bit e_tick[NCH], e_clk[NCH], e_ack[NCH];
  int tests = 0, fails = 0;

  typedef struct {
    bit en; bit mode; bit ld; int din;
    bit tk; bit ck; bit ak;
  } vec_t;
  vec_t tbl[20];

  task automatic model_step();
    for (int ch = 0; ch < NCH; ch++) begin
      int v;
      if (rst) begin
        m_d[ch] = DD; m_run[ch] = 0; m_pend[ch] = -1; m_pos[ch] = 0;
        e_tick[ch] = 0; e_clk[ch] = 0; e_ack[ch] = 0;
        continue;
      end
      if (div_load[ch]) begin
        v = int'(div_in[ch*W +: W]);
        m_pend[ch] = (v < 2) ? 2 : v;
      end
      e_ack[ch] = 0; e_tick[ch] = 0; e_clk[ch] = 0;
      if (!en[ch]) begin
        if (m_pend[ch] >= 0) begin
          m_d[ch] = m_pend[ch]; m_pend[ch] = -1; e_ack[ch] = 1;
        end
        m_run[ch] = 0;
      end else begin
        if (!m_run[ch] || m_pos[ch] == m_d[ch] - 1) begin
          if (m_pend[ch] >= 0) begin
            m_d[ch] = m_pend[ch]; m_pend[ch] = -1; e_ack[ch] = 1;
          end
          m_pos[ch] = 0; m_run[ch] = 1; e_tick[ch] = 1;
        end else begin
          m_pos[ch]++;
        end
        e_clk[ch] = mode[ch] ? e_tick[ch] : (m_pos[ch] < (m_d[ch] + 1) / 2);
      end
    end
  endtask

  task automatic cycle(input string name);
    model_step();
    @(posedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      tests++;
      if ({tick[ch], clkout[ch], div_ack[ch]} !== {e_tick[ch], e_clk[ch], e_ack[ch]}) begin
        fails++;
        $display("FAIL %s ch%0d t=%0t: tick/clkout/ack got %b%b%b expected %b%b%b", name, ch, $time,
                 tick[ch], clkout[ch], div_ack[ch], e_tick[ch], e_clk[ch], e_ack[ch]);
      end
    end
  endtask

  task automatic set_ch(input int ch, input bit e, input bit m, input bit ld, input int d);
    en[ch] = e; mode[ch] = m; div_load[ch] = ld; div_in[ch*W +: W] = d[W-1:0];
  endtask

  // Distance between the next two ticks on a channel must equal the divisor.
  task automatic check_period(input int ch, input int exp_p, input string name);
    int first = -1, second = -1;
    for (int i = 0; i < 700 && second < 0; i++) begin
      cycle(name);
      if (tick[ch]) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    tests++;
    if (second < 0 || second - first != exp_p) begin
      fails++;
      $display("FAIL %s period ch%0d: got %0d expected %0d", name, ch,
               (second < 0) ? -1 : second - first, exp_p);
    end
  endtask

  initial begin
    int acks;
    bit seen;
    // en, mode, ld, din, tick, clkout, ack -- channel 0, others idle
    tbl[0]  = '{0, 0, 1, 4, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 1, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{1, 0, 1, 6, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 1, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 1, 1, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[18] = '{1, 1, 0, 0, 1, 1, 0};
    tbl[19] = '{1, 1, 0, 0, 0, 0, 0};

    rst = 1; en = '0; mode = '0; div_load = '0; div_in = '0;
    cycle("reset");
    cycle("reset");
    rst = 0;
    cycle("idle");

    for (int i = 0; i < 20; i++) begin
      set_ch(0, tbl[i].en, tbl[i].mode, tbl[i].ld, tbl[i].din);
      cycle("table");
      tests++;
      if ({tick[0], clkout[0], div_ack[0]} !== {tbl[i].tk, tbl[i].ck, tbl[i].ak}) begin
        fails++;
        $display("FAIL table[%0d]: tick/clkout/ack got %b%b%b expected %b%b%b", i,
                 tick[0], clkout[0], div_ack[0], tbl[i].tk, tbl[i].ck, tbl[i].ak);
      end
    end

    // Default divisor after reset, seen on an untouched channel.
    set_ch(2, 1, 0, 0, 0);
    check_period(2, DD, "default_div");
    set_ch(2, 0, 0, 0, 0);

    // D=5 square, then D=3 pulse.
    set_ch(0, 0, 0, 1, 5); cycle("d5_load");
    set_ch(0, 1, 0, 0, 0); check_period(0, 5, "d5_square");
    for (int i = 0; i < 10; i++) cycle("d5_run");
    set_ch(0, 0, 1, 1, 3); cycle("d3_load");
    set_ch(0, 1, 1, 0, 0); check_period(0, 3, "d3_pulse");
    for (int i = 0; i < 9; i++) cycle("d3_run");

    // Clamp: 0 then 1 both become 2.
    set_ch(0, 0, 0, 1, 0); cycle("clamp0");
    set_ch(0, 0, 0, 1, 1); cycle("clamp1");
    set_ch(0, 1, 0, 0, 0); check_period(0, 2, "clamp");

    // Two loads within one period: only the last applies, one ack.
    set_ch(0, 0, 0, 1, 20); cycle("ll_setup");
    set_ch(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("ll_run");
    set_ch(0, 1, 0, 1, 7); cycle("ll_load7");
    set_ch(0, 1, 0, 0, 0); cycle("ll_run");
    set_ch(0, 1, 0, 1, 9); cycle("ll_load9");
    set_ch(0, 1, 0, 0, 0);
    acks = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle("ll_wait");
      acks += int'(div_ack[0]);
      seen = tick[0];
    end
    tests++;
    if (!seen || acks != 1) begin
      fails++;
      $display("FAIL last_load_ack: got acks=%0d wrap=%0d expected acks=1 wrap=1", acks, seen);
    end
    check_period(0, 9, "last_load");

    // en drop mid-high phase, 10 cycles idle, re-enable.
    set_ch(0, 0, 0, 1, 6); cycle("en_setup");
    set_ch(0, 1, 0, 0, 0); cycle("en_run");
    set_ch(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle("en_off");
    set_ch(0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle("en_reon");

    // Reset mid-period with a pending load.
    set_ch(0, 0, 0, 1, 9); cycle("rst_setup");
    set_ch(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("rst_run");
    set_ch(0, 1, 0, 1, 5); cycle("rst_pend");
    set_ch(0, 1, 0, 0, 0);
    rst = 1; cycle("rst_mid");
    tests++;
    if ({tick, clkout, div_ack} !== '0) begin
      fails++;
      $display("FAIL rst_outputs: got %b expected all zero", {tick, clkout, div_ack});
    end
    rst = 0; cycle("rst_first");
    tests++;
    if (div_ack[0] !== 1'b0 || tick[0] !== 1'b1) begin
      fails++;
      $display("FAIL rst_pend_dropped: ack/tick got %b%b expected 01", div_ack[0], tick[0]);
    end
    check_period(0, DD, "rst_div");

    // Concurrent channels, D=2 and D=7.
    set_ch(0, 0, 0, 1, 2); set_ch(1, 0, 0, 1, 7); cycle("cc_load");
    set_ch(0, 1, 0, 0, 0); set_ch(1, 1, 0, 0, 0);
    check_period(1, 7, "cc_ch1");
    check_period(0, 2, "cc_ch0");

    // Largest divisor.
    set_ch(3, 0, 0, 1, 255); cycle("max_load");
    set_ch(3, 1, 0, 0, 0); check_period(3, 255, "max_div");

    // Random traffic on all channels.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        en[ch] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) mode[ch] = ~mode[ch];
        div_load[ch] = ($urandom_range(0, 14) == 0);
        div_in[ch*W +: W] = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      end
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
